alu_bus_driver: RTL and testbench

- Host-side sequencer for the ALU add/sub datapath's shared inbus/outbus protocol.
- Accepts an operation command (op, A, B) on a valid/ready interface and raises ALU enable/start.
- Serialises A then B onto the ALU inbus on the cycles the ALU loads M and Q, waits for ALU done, captures outbus and returns the result on a valid/ready response interface.

---
 rtl/alu_bus_driver.sv | 216 +++++++++++++++++++++
 tb/tb_alu_bus_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_bus_driver.sv
// Host-side sequencer for the ALU shared inbus/outbus add/sub protocol.
// Optional WAIT timeout with error response: define ALU_BUS_DRIVER_TIMEOUT_EN.
module alu_bus_driver #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             alu_enable,
    output logic             alu_start,
    output logic             alu_op,
    output logic [WIDTH-1:0] alu_inbus,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_outbus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SEND_M = 3'd2,
        S_SEND_Q = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             alu_enable_q, alu_enable_d;
    logic             alu_start_q, alu_start_d;
    logic             alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_inbus_q, alu_inbus_d;

`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // State, operand and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            rsp_data_q <= '0;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
            cnt_q      <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
            cnt_q      <= cnt_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
        cnt_d      = cnt_q;
        rsp_err_d  = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    state_d = S_START;
                end
            end
            S_START:  state_d = S_SEND_M;
            S_SEND_M: state_d = S_SEND_Q;
            S_SEND_Q: begin
                state_d = S_WAIT;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
                // Counter hits zero on the last allowed WAIT cycle
                cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
            end
            S_WAIT: begin
                if (alu_done) begin
                    rsp_data_d = alu_outbus;
                    state_d    = S_RESP;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they are registered yet state-aligned
    always_comb begin
        cmd_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        busy_d       = 1'b0;
        alu_enable_d = 1'b0;
        alu_start_d  = 1'b0;
        alu_op_d     = 1'b0;
        alu_inbus_d  = '0;
        case (state_d)
            S_IDLE: cmd_ready_d = 1'b1;
            S_START: begin
                busy_d       = 1'b1;
                alu_enable_d = 1'b1;
                alu_start_d  = 1'b1;
                alu_op_d     = op_d;
            end
            S_SEND_M: begin
                busy_d       = 1'b1;
                alu_enable_d = 1'b1;
                alu_op_d     = op_d;
                alu_inbus_d  = a_d;
            end
            S_SEND_Q: begin
                busy_d       = 1'b1;
                alu_enable_d = 1'b1;
                alu_op_d     = op_d;
                alu_inbus_d  = b_d;
            end
            S_WAIT: begin
                busy_d       = 1'b1;
                alu_enable_d = 1'b1;
                alu_op_d     = op_d;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
                if (cnt_d == '0) begin
                    alu_enable_d = 1'b0;
                end
`endif
            end
            S_RESP: begin
                busy_d      = 1'b1;
                rsp_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            alu_enable_q <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_op_q     <= 1'b0;
            alu_inbus_q  <= '0;
        end else begin
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            alu_enable_q <= alu_enable_d;
            alu_start_q  <= alu_start_d;
            alu_op_q     <= alu_op_d;
            alu_inbus_q  <= alu_inbus_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign alu_enable = alu_enable_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_op_q;
    assign alu_inbus  = alu_inbus_q;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bus_driver.sv
// Randomized self-checking bench for alu_bus_driver; the bench plays the ALU.
// Build with ALU_BUS_DRIVER_TIMEOUT_EN to exercise the timeout response (TIMEOUT=4).
module tb_alu_bus_driver;

    localparam int unsigned W = 8;
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 15;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_op;
    logic [W-1:0] cmd_a, cmd_b;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [W-1:0] rsp_data;
    logic         busy, alu_enable, alu_start, alu_op, alu_done;
    logic [W-1:0] alu_inbus, alu_outbus;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_bus_driver #(.WIDTH(W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .alu_enable(alu_enable), .alu_start(alu_start), .alu_op(alu_op),
        .alu_inbus(alu_inbus), .alu_done(alu_done), .alu_outbus(alu_outbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_enable"},    32'(alu_enable), 32'd0);
        check({tag, "_start"},     32'(alu_start), 32'd0);
        check({tag, "_alu_op"},    32'(alu_op),    32'd0);
        check({tag, "_inbus"},     32'(alu_inbus), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    endtask

    // One full transaction: handshake, protocol checks, ALU reply after lat extra WAIT cycles
    task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input int stall, input bit stray, output int acc_cyc);
        logic [W-1:0] m_cap, q_cap, exp_res;
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_enable", 32'(alu_enable), 32'd0);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        acc_cyc = cyc;
        step();                                  // cycle 1: START
        cmd_valid = 1'b0; cmd_a = W'($urandom); cmd_b = W'($urandom);
        check("start_pulse", 32'(alu_start), 32'd1);
        check("start_enable", 32'(alu_enable), 32'd1);
        check("start_inbus", 32'(alu_inbus), 32'd0);
        check("start_op", 32'(alu_op), 32'(op));
        check("start_busy_ready", {30'd0, busy, cmd_ready}, 32'b10);
        if (stray) begin
            alu_done = 1'b1; alu_outbus = W'($urandom);
        end
        step();                                  // cycle 2: SEND_M
        m_cap = alu_inbus;
        check("sendm_inbus", 32'(alu_inbus), 32'(a));
        check("sendm_start", 32'(alu_start), 32'd0);
        step();                                  // cycle 3: SEND_Q
        alu_done = 1'b0;
        q_cap = alu_inbus;
        check("sendq_inbus", 32'(alu_inbus), 32'(b));
        check("sendq_op", 32'(alu_op), 32'(op));
        exp_res = op ? W'(m_cap - q_cap) : W'(m_cap + q_cap);
        step();                                  // cycle 4: WAIT
        for (int i = 0; i < lat; i++) begin
            check("wait_inbus", 32'(alu_inbus), 32'd0);
            check("wait_enable_novalid", {30'd0, alu_enable, rsp_valid}, 32'b10);
            step();
        end
        check("wait_op", 32'(alu_op), 32'(op));
        alu_done = 1'b1; alu_outbus = exp_res;
        step();                                  // RESP
        alu_done = 1'b0; alu_outbus = W'($urandom);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp_res));
        check("rsp_err", 32'(rsp_err), 32'd0);
        check("rsp_enable", 32'(alu_enable), 32'd0);
        check("rsp_op", 32'(alu_op), 32'd0);
        check("rsp_ready_low", 32'(cmd_ready), 32'd0);
        if (stall > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                check("stall_valid", 32'(rsp_valid), 32'd1);
                check("stall_data", 32'(rsp_data), 32'(exp_res));
                check("stall_enable_ready", {30'd0, alu_enable, cmd_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        step();                                  // back to IDLE
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int acc0, acc1, acc2;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1; alu_done = 1'b0; alu_outbus = '0;
        step(); step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Directed add and subtract with backpressure
        do_op(1'b0, 8'h25, 8'h13, 0, 0, 1'b0, acc0);
        do_op(1'b1, 8'h10, 8'h20, 0, 3, 1'b0, acc0);

        // Back-to-back: accepts 6 cycles apart
        do_op(1'b0, 8'hFF, 8'h01, 0, 0, 1'b0, acc0);
        do_op(1'b1, 8'h00, 8'h01, 0, 0, 1'b0, acc1);
        do_op(1'b0, 8'h7F, 8'h80, 0, 0, 1'b0, acc2);
        check("b2b_gap1", 32'(acc1 - acc0), 32'd6);
        check("b2b_gap2", 32'(acc2 - acc1), 32'd6);

        // Stray done during SEND_M
        do_op(1'b0, 8'h3C, 8'h44, 1, 0, 1'b1, acc0);

        // Reset mid-op during SEND_Q
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 8'hAA; cmd_b = 8'h55;
        step(); cmd_valid = 1'b0;
        step(); step();
        check("midop_in_sendq", 32'(alu_inbus), 32'h55);
        rst = 1'b1;
        #1;
        check_reset_outputs("midop_rst");
        step();
        rst = 1'b0;
        alu_done = 1'b1; alu_outbus = 8'h99;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midop_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        end
        alu_done = 1'b0;
        do_op(1'b0, 8'h01, 8'h02, 0, 0, 1'b0, acc0);

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            do_op(1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom), acc0);
        end

        // ALU never answers
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_a = 8'h12; cmd_b = 8'h34;
        step(); cmd_valid = 1'b0;
        step(); step(); step();                  // cycle 4: first WAIT
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            check("to_wait_valid", 32'(rsp_valid), 32'd0);
            check("to_wait_enable", 32'(alu_enable), 32'd1);
            step();
        end
        check("to_expiry_enable", {30'd0, alu_enable, rsp_valid}, 32'd0);
        step();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_data", 32'(rsp_data), 32'd0);
        step();
        check("to_post_ready", 32'(cmd_ready), 32'd1);
        do_op(1'b1, 8'h05, 8'h09, 2, 1, 1'b0, acc0);
`else
        for (int i = 0; i < 100; i++) begin
            check("hang_busy_novalid", {30'd0, busy, rsp_valid}, 32'b10);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("hang_rst");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
